dvp_pixel_reader: RTL

- Parametrised successor to the team's RGB565 camera byte reader on the OV-sensor DVP interface.
- Packs BUS_W-bit bus words into pixels of BYTES_PER_PIX words, with selectable byte order.
- Functional start/stop control and configurable frame skip; hstart/vstart flags aligned with the first pixel of a line/frame.
- Measures line and frame lengths; flags partial pixels. Feeds the downstream pixel pipeline in the pclk domain.

---
 rtl/dvp_pkg.sv | 16 +
 rtl/dvp_byte_packer.sv | 74 +++++++
 rtl/dvp_pixel_reader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP pixel reader: capture FSM encoding and the
// all-ones value that the length counters saturate at.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SKIP,
        ST_WAIT,
        ST_CAPTURE
    } dvp_state_e;

    localparam int unsigned SAT_W = 64;
    localparam logic [SAT_W-1:0] SAT_ONES = '1;

endpackage

// File: rtl/dvp_byte_packer.sv
// Packs BUS_W-bit camera words into BYTES_PER_PIX-word pixels; strobes pixel_valid
// one cycle after the last word lands and exposes the word index for partial-line checks.
module dvp_byte_packer
    import dvp_pkg::*;
#(
    parameter int BUS_W         = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int MSB_FIRST     = 0
) (
    input  logic                           pclk,
    input  logic                           rst_n,
    input  logic [BUS_W-1:0]               din,
    input  logic                           word_en,
    input  logic                           href,
    output logic                           word_last,
    output logic                           idx_nz,
    output logic                           pixel_valid,
    output logic [BUS_W*BYTES_PER_PIX-1:0] pixel
);

    localparam int PIX_W = BUS_W * BYTES_PER_PIX;
    localparam int IDX_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_PIX - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PIX_W-1:0] acc_q, acc_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic             full_q, full_d;
    logic             valid_q, valid_d;
    int               slot;

    always_comb begin
        idx_d   = idx_q;
        acc_d   = acc_q;
        full_d  = 1'b0;
        valid_d = full_q;
        pixel_d = full_q ? acc_q : pixel_q;
        slot    = (MSB_FIRST != 0) ? (BYTES_PER_PIX - 1 - int'(idx_q)) : int'(idx_q);
        if (word_en) begin
            acc_d[slot*BUS_W +: BUS_W] = din;
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                full_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (!href) begin
            // a word left over when href drops is a partial pixel and is dropped here
            idx_d = '0;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            acc_q   <= '0;
            pixel_q <= '0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            pixel_q <= pixel_d;
            full_q  <= full_d;
            valid_q <= valid_d;
        end
    end

    assign word_last   = word_en && (idx_q == IDX_LAST);
    assign idx_nz      = (idx_q != '0);
    assign pixel_valid = valid_q;
    assign pixel       = pixel_q;

endmodule

// File: rtl/dvp_pixel_reader.sv
// DVP camera pixel reader: start/stop/skip sequencing, sync edge detection, line/frame lengths.
// Build option DVP_INPUT_REG_EN adds an input register on din/href/vsync (+1 cycle latency).
//
// state   | meaning
// IDLE    | stopped, waiting for start
// ARMED   | started, waiting for the first vsync rise
// SKIP    | discarding SKIP_FRAMES whole frames
// WAIT    | between frames, waiting for vsync to fall
// CAPTURE | packing pixels of the current frame
module dvp_pixel_reader
    import dvp_pkg::*;
#(
    parameter int BUS_W         = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int MSB_FIRST     = 0,
    parameter int SKIP_FRAMES   = 1,
    parameter int CNT_W         = 16
) (
    input  logic                           pclk,
    input  logic                           rst_n,
    input  logic [BUS_W-1:0]               din,
    input  logic                           vsync,
    input  logic                           href,
    input  logic                           start,
    input  logic                           stop,
    output logic                           pixel_valid,
    output logic [BUS_W*BYTES_PER_PIX-1:0] pixel,
    output logic                           hstart,
    output logic                           vstart,
    output logic [CNT_W-1:0]               hlen,
    output logic [CNT_W-1:0]               vlen,
    output logic                           frame_done,
    output logic                           busy,
    output logic                           err_partial
);

    localparam logic [CNT_W-1:0] CNT_MAX = SAT_ONES[CNT_W-1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [BUS_W-1:0] din_s;
    logic             href_s, vsync_s;

`ifdef DVP_INPUT_REG_EN
    logic [BUS_W-1:0] din_r_q;
    logic             href_r_q, vsync_r_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            din_r_q   <= '0;
            href_r_q  <= 1'b0;
            vsync_r_q <= 1'b0;
        end else begin
            din_r_q   <= din;
            href_r_q  <= href;
            vsync_r_q <= vsync;
        end
    end

    assign din_s   = din_r_q;
    assign href_s  = href_r_q;
    assign vsync_s = vsync_r_q;
`else
    assign din_s   = din;
    assign href_s  = href;
    assign vsync_s = vsync;
`endif

    dvp_state_e       state_q, state_d;
    logic [3:0]       skip_q, skip_d;
    logic             stop_pend_q, stop_pend_d;
    logic             href_prev_q, href_prev_d;
    logic             vsync_prev_q, vsync_prev_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] ln_cnt_q, ln_cnt_d;
    logic [CNT_W-1:0] hlen_q, hlen_d;
    logic [CNT_W-1:0] vlen_q, vlen_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             hpend_q, hpend_d;
    logic             vpend_q, vpend_d;

    logic href_rise, href_fall, vs_rise, vs_fall;
    logic word_en, word_last, idx_nz;

    assign href_rise = href_s && !href_prev_q;
    assign href_fall = !href_s && href_prev_q;
    assign vs_rise   = vsync_s && !vsync_prev_q;
    assign vs_fall   = !vsync_s && vsync_prev_q;
    assign word_en   = (state_q == ST_CAPTURE) && href_s && !vsync_s;

    dvp_byte_packer #(
        .BUS_W         (BUS_W),
        .BYTES_PER_PIX (BYTES_PER_PIX),
        .MSB_FIRST     (MSB_FIRST)
    ) u_packer (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .din         (din_s),
        .word_en     (word_en),
        .href        (href_s),
        .word_last   (word_last),
        .idx_nz      (idx_nz),
        .pixel_valid (pixel_valid),
        .pixel       (pixel)
    );

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        stop_pend_d  = stop_pend_q;
        href_prev_d  = href_s;
        vsync_prev_d = vsync_s;
        pix_cnt_d    = pix_cnt_q;
        ln_cnt_d     = ln_cnt_q;
        hlen_d       = hlen_q;
        vlen_d       = vlen_q;
        err_d        = err_q;
        done_d       = 1'b0;
        hpend_d      = pixel_valid ? 1'b0 : hpend_q;
        vpend_d      = pixel_valid ? 1'b0 : vpend_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_ARMED;
                    err_d   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
                    if (SKIP_FRAMES > 0) begin
                        state_d = ST_SKIP;
                        skip_d  = 4'(SKIP_FRAMES);
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_SKIP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
                    if (skip_q == 4'd1) state_d = ST_WAIT;
                    else                skip_d  = skip_q - 4'd1;
                end
            end
            ST_WAIT: begin
                if (stop) stop_pend_d = 1'b1;
                if (vs_fall) begin
                    state_d = ST_CAPTURE;
                    vpend_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (stop) stop_pend_d = 1'b1;
                if (href_rise) begin
                    ln_cnt_d = sat_inc(ln_cnt_q);
                    hpend_d  = 1'b1;
                end
                if (word_last) pix_cnt_d = sat_inc(pix_cnt_q);
                if (href_fall) begin
                    hlen_d    = pix_cnt_q;
                    pix_cnt_d = '0;
                    if (idx_nz) err_d = 1'b1;
                end
                if (vs_rise) begin
                    vlen_d   = ln_cnt_q;
                    ln_cnt_d = '0;
                    done_d   = 1'b1;
                    state_d  = (stop_pend_q || stop) ? ST_IDLE : ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) stop_pend_d = 1'b0;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            skip_q       <= '0;
            stop_pend_q  <= 1'b0;
            href_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
            pix_cnt_q    <= '0;
            ln_cnt_q     <= '0;
            hlen_q       <= '0;
            vlen_q       <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            hpend_q      <= 1'b0;
            vpend_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            stop_pend_q  <= stop_pend_d;
            href_prev_q  <= href_prev_d;
            vsync_prev_q <= vsync_prev_d;
            pix_cnt_q    <= pix_cnt_d;
            ln_cnt_q     <= ln_cnt_d;
            hlen_q       <= hlen_d;
            vlen_q       <= vlen_d;
            err_q        <= err_d;
            done_q       <= done_d;
            hpend_q      <= hpend_d;
            vpend_q      <= vpend_d;
        end
    end

    assign hstart      = pixel_valid && hpend_q;
    assign vstart      = pixel_valid && vpend_q;
    assign hlen        = hlen_q;
    assign vlen        = vlen_q;
    assign frame_done  = done_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_partial = err_q;

endmodule
